// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
// No logic here. The state encoding is fixed so that debug probes stay stable.
package ps2_pkg;

    typedef enum logic [2:0] {
        PS2_IDLE    = 3'd0,
        PS2_INHIBIT = 3'd1,
        PS2_RTS     = 3'd2,
        PS2_SHIFT   = 3'd3,
        PS2_ACK     = 3'd4,
        PS2_RELEASE = 3'd5
    } ps2_state_e;

    localparam logic [1:0] PS2_ERR_NONE = 2'b00;
    localparam logic [1:0] PS2_ERR_RTS  = 2'b01;
    localparam logic [1:0] PS2_ERR_XFER = 2'b10;
    localparam logic [1:0] PS2_ERR_NACK = 2'b11;

    // Start + 8 data + parity + stop.
    localparam int PS2_FRAME_BITS = 11;

    localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

    // Bits shifted out after the start bit, LSB first.
    typedef struct packed {
        logic       stop;
        logic       parity;
        logic [7:0] data;
    } ps2_frame_t;

    function automatic logic ps2_odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchronizes one raw PS/2 line, rejects glitches shorter than FILTER_CYCLES and flags falling edges.
// Latency: 2 sync cycles + FILTER_CYCLES to the filtered level; no backpressure (free-running).
module ps2_line_filter #(
    parameter int FILTER_CYCLES = 4
) (
    input  logic clk_100mHz,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Idle bus is pulled up, so everything resets to the high level.
    always_ff @(posedge clk_100mHz or negedge reset) begin
        if (!reset) begin
            sync  <= 2'b11;
            cnt   <= '0;
            level <= 1'b1;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], pin};
            fall <= 1'b0;
            if (sync[1] == level) begin
                cnt <= '0;
            end else if (cnt == CW'(FILTER_CYCLES - 1)) begin
                level <= sync[1];
                fall  <= level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, shift on device clock, check ACK.
// Latency: pin edge to data_oe in 2+FILTER_CYCLES+1 cycles; tx_ready low from accept until the cycle after done/error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int CLK_HZ              = 100_000_000,
    parameter int INHIBIT_CYCLES      = 12_000,
    parameter int RTS_TIMEOUT_CYCLES  = 1_500_000,
    parameter int XFER_TIMEOUT_CYCLES = 200_000,
    parameter int FILTER_CYCLES       = 4
) (
    input  logic       clk_100mHz,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_error,
    output logic [1:0] tx_err_code,
    output logic       rx_inhibit,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    if (CLK_HZ < 1 || FILTER_CYCLES < 1 || INHIBIT_CYCLES < 1 ||
        RTS_TIMEOUT_CYCLES < 1 || XFER_TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("ps2_host_tx: all cycle parameters must be positive");
    end

    localparam logic [2:0] S_IDLE    = PS2_IDLE;
    localparam logic [2:0] S_INHIBIT = PS2_INHIBIT;
    localparam logic [2:0] S_RTS     = PS2_RTS;
    localparam logic [2:0] S_SHIFT   = PS2_SHIFT;
    localparam logic [2:0] S_ACK     = PS2_ACK;
    localparam logic [2:0] S_RELEASE = PS2_RELEASE;

    localparam int T_A   = (RTS_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES) ? RTS_TIMEOUT_CYCLES : XFER_TIMEOUT_CYCLES;
    localparam int T_MAX = (T_A > INHIBIT_CYCLES) ? T_A : INHIBIT_CYCLES;
    localparam int TW    = $clog2(T_MAX + 1);
    localparam int BW    = $clog2(PS2_FRAME_BITS + 1);

    logic [2:0]                  state;
    logic [PS2_FRAME_BITS-2:0]   frame;
    logic [BW-1:0]               bit_cnt;
    logic [TW-1:0]               timer;
    logic                        clk_seen_high;
    logic                        clk_lvl, clk_fall;
    logic                        data_lvl, data_fall;
    ps2_frame_t                  new_frame;

    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_clk_filter (
        .clk_100mHz (clk_100mHz),
        .reset      (reset),
        .pin        (ps2_clk_in),
        .level      (clk_lvl),
        .fall       (clk_fall)
    );

    // Data falling edges are not needed; only the level is sampled at clock edges.
    ps2_line_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_data_filter (
        .clk_100mHz (clk_100mHz),
        .reset      (reset),
        .pin        (ps2_data_in),
        .level      (data_lvl),
        .fall       (data_fall)
    );

    assign new_frame  = '{stop: 1'b1, parity: ps2_odd_parity(tx_data), data: tx_data};
    assign tx_ready   = (state == S_IDLE) && !tx_done && !tx_error;
    assign rx_inhibit = (state != S_IDLE);

    always_ff @(posedge clk_100mHz or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            frame         <= '0;
            bit_cnt       <= '0;
            timer         <= '0;
            clk_seen_high <= 1'b0;
            ps2_clk_oe    <= 1'b0;
            ps2_data_oe   <= 1'b0;
            tx_done       <= 1'b0;
            tx_error      <= 1'b0;
            tx_err_code   <= PS2_ERR_NONE;
        end else begin
            tx_done  <= 1'b0;
            tx_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        frame       <= new_frame;
                        bit_cnt     <= '0;
                        timer       <= '0;
                        tx_err_code <= PS2_ERR_NONE;
                        ps2_clk_oe  <= 1'b1;
                        state       <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    // Start bit goes out as clock is released: this is the request-to-send.
                    if (timer == TW'(INHIBIT_CYCLES - 1)) begin
                        ps2_clk_oe    <= 1'b0;
                        ps2_data_oe   <= 1'b1;
                        timer         <= '0;
                        clk_seen_high <= 1'b0;
                        state         <= S_RTS;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                S_RTS: begin
                    if (timer == TW'(RTS_TIMEOUT_CYCLES - 1)) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_error    <= 1'b1;
                        tx_err_code <= PS2_ERR_RTS;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                        // The filtered clock still shows our own inhibit low; wait for it to rise first.
                        if (!clk_seen_high) begin
                            if (clk_lvl) clk_seen_high <= 1'b1;
                        end else if (clk_fall) begin
                            ps2_data_oe <= ~frame[0];
                            frame       <= frame >> 1;
                            bit_cnt     <= BW'(1);
                            timer       <= '0;
                            state       <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT, S_ACK, S_RELEASE: begin
                    if (timer == TW'(XFER_TIMEOUT_CYCLES - 1)) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_error    <= 1'b1;
                        tx_err_code <= PS2_ERR_XFER;
                        state       <= S_IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                        if (state == S_SHIFT) begin
                            if (clk_fall) begin
                                ps2_data_oe <= ~frame[0];
                                frame       <= frame >> 1;
                                bit_cnt     <= bit_cnt + BW'(1);
                                if (bit_cnt == BW'(PS2_FRAME_BITS - 2)) state <= S_ACK;
                            end
                        end else if (state == S_ACK) begin
                            if (clk_fall) begin
                                if (!data_lvl) begin
                                    state <= S_RELEASE;
                                end else begin
                                    ps2_data_oe <= 1'b0;
                                    tx_error    <= 1'b1;
                                    tx_err_code <= PS2_ERR_NACK;
                                    state       <= S_IDLE;
                                end
                            end
                        end else if (clk_lvl && data_lvl) begin
                            tx_done <= 1'b1;
                            state   <= S_IDLE;
                        end
                    end
                end
                default: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH    = 20;
    localparam int RTS_TO = 400;
    localparam int XFER_TO = 3000;
    localparam int FILT   = 4;
    localparam int HALF   = 30;
    localparam int BUDGET = INH + RTS_TO + XFER_TO + 2000;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_done, tx_error, rx_inhibit;
    logic [1:0] tx_err_code;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk_low, dev_data_low;
    logic       clk_line, data_line;

    assign clk_line  = !(ps2_clk_oe || dev_clk_low);
    assign data_line = !(ps2_data_oe || dev_data_low);

    ps2_host_tx #(
        .CLK_HZ              (100_000_000),
        .INHIBIT_CYCLES      (INH),
        .RTS_TIMEOUT_CYCLES  (RTS_TO),
        .XFER_TIMEOUT_CYCLES (XFER_TO),
        .FILTER_CYCLES       (FILT)
    ) dut (
        .clk_100mHz  (clk),
        .reset       (reset),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_error    (tx_error),
        .tx_err_code (tx_err_code),
        .rx_inhibit  (rx_inhibit),
        .ps2_clk_in  (clk_line),
        .ps2_data_in (data_line),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0, errors = 0;
    int done_cnt = 0, err_cnt = 0, done_cyc = 0, err_cyc = 0;
    int pulse_viol = 0, oe_run = 0, last_inh = 0;

    always @(negedge clk) begin
        if (tx_done)  begin done_cnt++; done_cyc = cyc; end
        if (tx_error) begin err_cnt++;  err_cyc  = cyc; end
        if ((tx_done || tx_error) && (tx_ready || (tx_done && tx_error))) pulse_viol++;
        if (ps2_clk_oe) oe_run++;
        else if (oe_run != 0) begin last_inh = oe_run; oe_run = 0; end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic send(input logic [7:0] d, output int acc);
        @(negedge clk);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk);
        acc      = cyc;
        tx_valid = 1'b0;
        chk("accept_clk_oe", ps2_clk_oe, 1);
        chk("accept_ready_low", tx_ready, 0);
        chk("accept_rx_inhibit", rx_inhibit, 1);
    endtask

    // Device: waits for RTS, then clocks nclk bits, sampling data at each rising edge.
    task automatic dev_run(input int nclk, input bit ack, input int glitch_at,
                           output logic [10:0] bits, output int first_fall);
        int w;
        bits = '1;
        first_fall = -1;
        if (nclk > 0) begin
            w = 0;
            @(negedge clk);
            while (!(clk_line && !data_line) && w < INH + 100) begin
                @(negedge clk);
                w++;
            end
            chk("rts_seen", (w < INH + 100), 1);
            repeat (10) @(negedge clk);
            for (int i = 0; i < nclk; i++) begin
                if (i == 10 && ack) begin
                    dev_data_low = 1'b1;
                    repeat (5) @(negedge clk);
                end
                dev_clk_low = 1'b1;
                if (i == 0) first_fall = cyc;
                repeat (HALF) @(negedge clk);
                dev_clk_low = 1'b0;
                bits[i] = data_line;
                if (i == glitch_at) begin
                    repeat (5) @(negedge clk);
                    dev_clk_low = 1'b1;
                    repeat (2) @(negedge clk);
                    dev_clk_low = 1'b0;
                    repeat (12) @(negedge clk);
                    chk("glitch_bit_cnt", 32'(dut.bit_cnt), glitch_at + 1);
                    repeat (HALF - 19) @(negedge clk);
                end else begin
                    repeat (HALF) @(negedge clk);
                end
            end
            dev_data_low = 1'b0;
        end
    endtask

    // Waits for a done/error pulse; mid-transfer it also offers a stray tx_valid that must be ignored.
    task automatic wait_result(input int d0, input int e0, output bit got);
        int n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < BUDGET) begin
            @(negedge clk);
            n++;
            if (n == 100) begin tx_data = 8'h00; tx_valid = 1'b1; end
            if (n == 103) tx_valid = 1'b0;
        end
        tx_valid = 1'b0;
        got = (n < BUDGET);
    endtask

    typedef struct {
        logic [7:0] data;
        int         nclk;
        bit         ack;
        bit         exp_done;
        logic [1:0] exp_code;
        logic       exp_par;
    } vec_t;

    initial begin
        vec_t        vecs[7];
        logic [10:0] bits;
        int          acc, ff, d0, e0;
        bit          got;

        vecs[0] = '{8'hED, 11, 1'b1, 1'b1, PS2_ERR_NONE, 1'b1};
        vecs[1] = '{8'hF4, 11, 1'b1, 1'b1, PS2_ERR_NONE, 1'b0};
        vecs[2] = '{8'hFF, 11, 1'b1, 1'b1, PS2_ERR_NONE, 1'b1};
        vecs[3] = '{8'h00, 11, 1'b1, 1'b1, PS2_ERR_NONE, 1'b1};
        vecs[4] = '{8'h01, 11, 1'b0, 1'b0, PS2_ERR_NACK, 1'b0};
        vecs[5] = '{8'hF4,  4, 1'b1, 1'b0, PS2_ERR_XFER, 1'b0};
        vecs[6] = '{8'hED,  0, 1'b1, 1'b0, PS2_ERR_RTS,  1'b1};

        reset = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
        dev_clk_low = 1'b0; dev_data_low = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", tx_ready, 1);
        chk("rst_done", tx_done, 0);
        chk("rst_error", tx_error, 0);
        chk("rst_code", tx_err_code, 0);
        chk("rst_inhibit", rx_inhibit, 0);
        chk("rst_clk_oe", ps2_clk_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        reset = 1'b1;
        repeat (5) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            d0 = done_cnt; e0 = err_cnt;
            send(vecs[v].data, acc);
            fork
                dev_run(vecs[v].nclk, vecs[v].ack, -1, bits, ff);
                wait_result(d0, e0, got);
            join
            repeat (5) @(negedge clk);
            chk("v_complete", got, 1);
            chk("v_done_pulses", done_cnt - d0, vecs[v].exp_done ? 1 : 0);
            chk("v_err_pulses", err_cnt - e0, vecs[v].exp_done ? 0 : 1);
            chk("v_err_code", tx_err_code, vecs[v].exp_code);
            chk("v_ready", tx_ready, 1);
            chk("v_clk_oe", ps2_clk_oe, 0);
            chk("v_data_oe", ps2_data_oe, 0);
            chk("v_inhibit_len", last_inh, INH);
            chk("v_pulse_rules", pulse_viol, 0);
            if (vecs[v].nclk == 11) begin
                chk("v_data_bits", bits[7:0], vecs[v].data);
                chk("v_parity", bits[8], vecs[v].exp_par);
                chk("v_stop", bits[9], 1);
            end
            if (vecs[v].exp_code == PS2_ERR_RTS)
                chk_rng("v_rts_time", err_cyc - acc, INH + RTS_TO - 2, INH + RTS_TO + 2);
            if (vecs[v].exp_code == PS2_ERR_XFER)
                chk_rng("v_xfer_time", err_cyc - ff, XFER_TO + 3, XFER_TO + FILT + 5);
        end

        // A short low glitch on the device clock inside a high phase must not count as an edge.
        d0 = done_cnt; e0 = err_cnt;
        send(PS2_CMD_SET_LEDS, acc);
        fork
            dev_run(11, 1'b1, 3, bits, ff);
            wait_result(d0, e0, got);
        join
        repeat (5) @(negedge clk);
        chk("glitch_done", done_cnt - d0, 1);
        chk("glitch_err", err_cnt - e0, 0);
        chk("glitch_bits", bits[7:0], 8'hED);
        chk("glitch_parity", bits[8], 1);

        // Reset in the middle of SHIFT.
        d0 = done_cnt; e0 = err_cnt;
        send(PS2_CMD_RESET, acc);
        fork
            dev_run(11, 1'b1, -1, bits, ff);
            begin
                repeat (INH + 15 + 8 * HALF) @(negedge clk);
                chk("pre_rst_inhibit", rx_inhibit, 1);
                reset = 1'b0;
                #1;
                chk("mid_rst_clk_oe", ps2_clk_oe, 0);
                chk("mid_rst_data_oe", ps2_data_oe, 0);
                chk("mid_rst_ready", tx_ready, 1);
                chk("mid_rst_code", tx_err_code, 0);
                repeat (3) @(negedge clk);
                reset = 1'b1;
            end
        join
        repeat (10) @(negedge clk);
        chk("post_rst_done", done_cnt - d0, 0);
        chk("post_rst_err", err_cnt - e0, 0);
        chk("post_rst_ready", tx_ready, 1);
        chk("post_rst_inhibit", rx_inhibit, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device PS/2 transmitter: accepts one command byte, performs the PS/2 request-to-send sequence, and shifts the frame out on the device-generated clock. It checks the device acknowledge and reports done or error. It sits next to the existing `Ps2Interface` receiver on the same `ps2_clk`/`ps2_data` pair and lets the game send keyboard commands such as 0xFF reset, 0xED set LEDs, and 0xF4 enable. The top level builds the open-drain inouts from the `*_oe` outputs: `oe=1` drives 0, and `oe=0` means high-Z.

## Interface
- `CLK_HZ`, 100_000_000, system clock frequency (informational).
- `INHIBIT_CYCLES`, 12_000, time clock is held low before RTS (120 µs).
- `RTS_TIMEOUT_CYCLES`, 1_500_000, limit from clock release to the first device falling edge (15 ms).
- `XFER_TIMEOUT_CYCLES`, 200_000, limit from the first falling edge to the acknowledge (2 ms).
- `FILTER_CYCLES`, 4, number of consecutive stable samples needed to accept a line level.
- `clk_100mHz`  in  1  system clock; all logic uses the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `tx_data`  in  8  command byte, sampled at the handshake.
- `tx_valid`  in  1  request to send `tx_data`.
- `tx_ready`  out  1  high only in IDLE; a transfer is accepted when `tx_valid && tx_ready`.
- `tx_done`  out  1  one-cycle pulse when the device ACKs and both lines have returned high.
- `tx_error`  out  1  one-cycle pulse when a transfer is aborted.
- `tx_err_code`  out  2  00 none, 01 RTS timeout, 10 transfer timeout, 11 NACK; held until the next accept.
- `rx_inhibit`  out  1  high whenever not IDLE; the receiver discards bytes while this is high.
- `ps2_clk_in`, `ps2_data_in`  in  1  raw pin levels, asynchronous.
- `ps2_clk_oe`, `ps2_data_oe`  out  1  pull the corresponding line low.

## Operation
- Reset values: `tx_ready=1`, and all other outputs 0. Both lines are released immediately on reset assertion.
- States are IDLE, INHIBIT, RTS, SHIFT, ACK, RELEASE.
- **IDLE**
  - On accept, latch `frame[9:0] = {1'b1, ~^tx_data, tx_data}`.
  - Clear `bit_cnt` and the timer, clear `tx_err_code`, then go to INHIBIT.
  - `tx_valid` while not IDLE is ignored.
- **INHIBIT**
  - `ps2_clk_oe=1`.
  - After `INHIBIT_CYCLES`, set `ps2_data_oe=1` (start bit / RTS), set `ps2_clk_oe=0` in the same cycle, and go to RTS.
- **RTS**
  - Data is held low.
  - First wait until the filtered clock reads high, then wait for a filtered falling edge.
  - On that edge, put `frame[0]` on the line (`data_oe = ~frame[0]`), shift, set `bit_cnt=1`, restart the timer, and go to SHIFT.
  - If the timer reaches `RTS_TIMEOUT_CYCLES`, abort with code 01.
- **SHIFT**
  - On each filtered falling edge, drive the next frame bit and increment `bit_cnt`.
  - Edge 10 drives the stop bit, which is a release of the line; then go to ACK.
- **ACK**
  - On the next falling edge (edge 11), sample the filtered data. A low level moves to RELEASE; a high level aborts with code 11.
- **RELEASE**
  - Wait until both filtered lines are high, pulse `tx_done`, and return to IDLE.
- The timer runs from edge 1 through RELEASE. Reaching `XFER_TIMEOUT_CYCLES` aborts with code 10.
- Abort releases both lines, pulses `tx_error`, sets `tx_err_code`, and returns to IDLE.
- Parity is odd: the parity bit is 1 when the byte contains an even number of ones.

## Timing
- Input path: 2-flop synchronizer, then a glitch filter. The filtered level changes only after `FILTER_CYCLES` equal samples. The falling-edge pulse occurs on the cycle the filtered level goes from 1 to 0.
- Pin edge to `ps2_data_oe` update is at most 2 + `FILTER_CYCLES` + 1 cycles (70 ns at default). This is well inside the device's ≥5 µs clock-low half-period.
- Accept to `ps2_clk_oe=1` takes 1 cycle. `ps2_clk_oe` stays high for exactly `INHIBIT_CYCLES`.
- `tx_done` and `tx_error` are never asserted in the same cycle. `tx_ready` returns high in the cycle after either pulse.
- Edges seen in IDLE or INHIBIT are ignored. This includes the falling edge produced by the block's own inhibit.

## Structure
- Package `ps2_pkg` holds:
  - the state enum;
  - error-code constants `PS2_ERR_NONE`, `PS2_ERR_RTS`, `PS2_ERR_XFER`, `PS2_ERR_NACK`;
  - `PS2_FRAME_BITS = 11`;
  - command constants 0xFF, 0xED, 0xF4.
- Sub-module `ps2_line_filter` contains the synchronizer, glitch filter, and fall detector. It is instantiated once for clock and once for data.

## Test plan
- Send 0xED with the device model answering normally. Bits sampled on rising edges must be 1,0,1,1,0,1,1,1, then parity 1, then stop 1. After the ACK, `tx_done` pulses once and `tx_err_code=00`.
- Send 0xF4, which has five ones. The parity bit must be 0, and `tx_done` must pulse.
- Device never clocks. `tx_error` pulses with code 01 exactly `INHIBIT_CYCLES + RTS_TIMEOUT_CYCLES` after accept (±filter latency), and both `oe` outputs are 0.
- Device leaves data high at the 11th clock. `tx_error` pulses with code 11, with no `tx_done`.
- Device stops after 4 clocks. `tx_error` pulses with code 10 `XFER_TIMEOUT_CYCLES` after edge 1.
- Two cases with short disturbances:
  - A 2-cycle low glitch on `ps2_clk_in` during SHIFT must not advance `bit_cnt`.
  - `reset` pulled low mid-SHIFT releases both lines within the same cycle and leaves `tx_ready=1` with no pulses.
